semaforo_ext_arbiter: RTL and testbench

Extension scheduler for the two-approach traffic-light controller. It synchronises the vehicle sensors and pedestrian buttons, latches pedestrian requests, and tracks which approach is being served from the light outputs. At each green-timer expiry it decides whether the current green may be extended, which drives the controller's iFFT input. A bounded extension budget guarantees the opposing approach is never starved.

---
 rtl/semaforo_pkg.sv | 16 +
 rtl/semaforo_ext_arbiter_if.sv | 33 +++
 rtl/semaforo_sync_edge.sv | 31 +++
 rtl/semaforo_ext_arbiter.sv | 134 +++++++++++++
 tb/tb_semaforo_ext_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light extension scheduler: service
// encodings and default scheduling parameters.
package semaforo_pkg;

    typedef enum logic [1:0] {
        SRV_IDLE = 2'b00,
        SRV_A    = 2'b01,
        SRV_B    = 2'b10,
        SRV_CLR  = 2'b11
    } serving_e;

    localparam int DEF_MAX_EXT     = 3;
    localparam int DEF_CNT_W       = 2;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/semaforo_ext_arbiter_if.sv
// Signal bundle between the light controller side and the extension scheduler.
interface semaforo_ext_arbiter_if #(
    parameter int CNT_W = 2
);
    logic             sensor_a;
    logic             sensor_b;
    logic             paso_a;
    logic             paso_b;
    logic             green_a;
    logic             green_b;
    logic             yellow_a;
    logic             yellow_b;
    logic             fin;
    logic             ext_grant;
    logic             ped_pend_a;
    logic             ped_pend_b;
    logic [CNT_W-1:0] ext_cnt;
    logic [1:0]       serving;
    logic             err;

    modport master (
        output sensor_a, sensor_b, paso_a, paso_b,
        output green_a, green_b, yellow_a, yellow_b, fin,
        input  ext_grant, ped_pend_a, ped_pend_b, ext_cnt, serving, err
    );

    modport slave (
        input  sensor_a, sensor_b, paso_a, paso_b,
        input  green_a, green_b, yellow_a, yellow_b, fin,
        output ext_grant, ped_pend_a, ped_pend_b, ext_cnt, serving, err
    );

endinterface

// File: rtl/semaforo_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with a synced level output
// and a single-cycle pulse on each rising edge of that level.
module semaforo_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge input, which keeps the shift chain a true chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/semaforo_ext_arbiter.sv
// Green-extension scheduler: tracks which approach is served from the lights,
// latches pedestrian requests and grants bounded green extensions (iFFT).
module semaforo_ext_arbiter
    import semaforo_pkg::*;
#(
    parameter int MAX_EXT     = DEF_MAX_EXT,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input logic                   clk,
    input logic                   rst,
    semaforo_ext_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_EXT);
    localparam logic [CNT_W-1:0] SAT_CNT = '1;

    // Bit order: sensor_a, sensor_b, paso_a, paso_b.
    logic [3:0] w_raw;
    logic [3:0] w_level;
    logic [3:0] w_rise;

    assign w_raw = {bus.paso_b, bus.paso_a, bus.sensor_b, bus.sensor_a};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        semaforo_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (w_raw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Sensors are used as levels, pedestrian buttons only as edges.
    logic w_sa, w_sb, w_paso_a_rise, w_paso_b_rise;
    logic w_unused;
    assign w_sa          = w_level[0];
    assign w_sb          = w_level[1];
    assign w_paso_a_rise = w_rise[2];
    assign w_paso_b_rise = w_rise[3];
    assign w_unused      = ^{w_level[3:2], w_rise[1:0]};

    serving_e         r_state, w_state_nxt;
    logic             r_ext_grant, w_grant_nxt;
    logic             r_ped_a, r_ped_b;
    logic [CNT_W-1:0] r_ext_cnt;
    logic             r_err;

    logic w_illegal, w_fault, w_enter_a, w_enter_b, w_state_chg;
    logic w_opp, w_budget_out;

    assign w_illegal = (bus.green_a & bus.green_b) |
                       ((bus.green_a | bus.green_b) & (bus.yellow_a | bus.yellow_b));
    assign w_fault   = w_illegal | r_err;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fault) begin
            w_state_nxt = SRV_IDLE;
        end else begin
            case (r_state)
                SRV_IDLE, SRV_CLR: begin
                    if (bus.green_a)      w_state_nxt = SRV_A;
                    else if (bus.green_b) w_state_nxt = SRV_B;
                end
                SRV_A:   if (bus.yellow_a) w_state_nxt = SRV_CLR;
                SRV_B:   if (bus.yellow_b) w_state_nxt = SRV_CLR;
                default: w_state_nxt = SRV_IDLE;
            endcase
        end
    end

    assign w_state_chg = (w_state_nxt != r_state);
    assign w_enter_a   = (w_state_nxt == SRV_A) && (r_state != SRV_A);
    assign w_enter_b   = (w_state_nxt == SRV_B) && (r_state != SRV_B);

    // Budget is spent only while the other approach is actually waiting.
    always_comb begin
        w_opp       = 1'b0;
        w_grant_nxt = 1'b0;
        case (r_state)
            SRV_A:   w_opp = w_sb | r_ped_b;
            SRV_B:   w_opp = w_sa | r_ped_a;
            default: w_opp = 1'b0;
        endcase
        w_budget_out = w_opp && (r_ext_cnt >= MAX_CNT);
        case (r_state)
            SRV_A:   w_grant_nxt = w_sa & ~r_ped_a & ~w_budget_out;
            SRV_B:   w_grant_nxt = w_sb & ~r_ped_b & ~w_sa & ~w_budget_out;
            default: w_grant_nxt = 1'b0;
        endcase
        if (w_fault) w_grant_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SRV_IDLE;
            r_ext_grant <= 1'b0;
            r_ped_a     <= 1'b0;
            r_ped_b     <= 1'b0;
            r_ext_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ext_grant <= w_grant_nxt;

            if (w_illegal) r_err <= 1'b1;

            // Clearing on service entry takes priority over a new press.
            if (w_enter_b)                             r_ped_a <= 1'b0;
            else if (w_paso_a_rise && !bus.green_b)    r_ped_a <= 1'b1;
            if (w_enter_a)                             r_ped_b <= 1'b0;
            else if (w_paso_b_rise && !bus.green_a)    r_ped_b <= 1'b1;

            if (w_state_chg) begin
                r_ext_cnt <= '0;
            end else if (bus.fin && r_ext_grant && (r_ext_cnt != SAT_CNT) &&
                         ((r_state == SRV_A) || (r_state == SRV_B))) begin
                r_ext_cnt <= r_ext_cnt + 1'b1;
            end
        end
    end

    assign bus.ext_grant  = r_ext_grant;
    assign bus.ped_pend_a = r_ped_a;
    assign bus.ped_pend_b = r_ped_b;
    assign bus.ext_cnt    = r_ext_cnt;
    assign bus.serving    = r_state;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_semaforo_ext_arbiter.sv
// Directed bench for the extension scheduler: a vector table for the steady
// green/extension phases plus hand sequences for pedestrians, faults and reset.
module tb_semaforo_ext_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    semaforo_ext_arbiter_if #(.CNT_W(2)) bus ();

    semaforo_ext_arbiter #(
        .MAX_EXT     (3),
        .CNT_W       (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ga, gb, ya, yb, fin, sa, sb;
        logic       e_grant;
        logic [1:0] e_cnt;
        logic [1:0] e_srv;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic ga, gb, ya, yb, fin, sa, sb,
                                input logic e_grant, input logic [1:0] e_cnt,
                                input logic [1:0] e_srv);
        vec_t v;
        v.ga = ga; v.gb = gb; v.ya = ya; v.yb = yb; v.fin = fin;
        v.sa = sa; v.sb = sb;
        v.e_grant = e_grant; v.e_cnt = e_cnt; v.e_srv = e_srv;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic grant, input logic pa,
                             input logic pb, input logic [1:0] cnt,
                             input logic [1:0] srv, input logic err);
        check({tag, ".ext_grant"},  {7'd0, bus.ext_grant},  {7'd0, grant});
        check({tag, ".ped_pend_a"}, {7'd0, bus.ped_pend_a}, {7'd0, pa});
        check({tag, ".ped_pend_b"}, {7'd0, bus.ped_pend_b}, {7'd0, pb});
        check({tag, ".ext_cnt"},    {6'd0, bus.ext_cnt},    {6'd0, cnt});
        check({tag, ".serving"},    {6'd0, bus.serving},    {6'd0, srv});
        check({tag, ".err"},        {7'd0, bus.err},        {7'd0, err});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic lights(input logic ga, gb, ya, yb);
        bus.green_a = ga; bus.green_b = gb; bus.yellow_a = ya; bus.yellow_b = yb;
    endtask

    // One-cycle button press, then three more cycles for sync, edge and latch.
    task automatic press_a();
        bus.paso_a = 1'b1;
        tick();
        bus.paso_a = 1'b0;
        tick(3);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.sensor_a = 0; bus.sensor_b = 0; bus.paso_a = 0; bus.paso_b = 0;
        bus.fin = 0;
        lights(0, 0, 0, 0);

        //             ga gb ya yb fin sa sb  grant cnt srv
        vecs[0]  = mk(0, 0, 0, 0, 0,  1, 0,  0,    0,  0);
        vecs[1]  = mk(1, 0, 0, 0, 0,  1, 0,  0,    0,  1);
        vecs[2]  = mk(1, 0, 0, 0, 0,  1, 0,  1,    0,  1);
        vecs[3]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    1,  1);
        vecs[4]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    2,  1);
        vecs[5]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    3,  1);
        vecs[6]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    3,  1);
        vecs[7]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    3,  1);
        vecs[8]  = mk(1, 0, 0, 0, 1,  1, 0,  1,    3,  1);
        vecs[9]  = mk(0, 0, 1, 0, 0,  1, 1,  1,    0,  3);
        vecs[10] = mk(0, 0, 1, 0, 0,  1, 1,  0,    0,  3);
        vecs[11] = mk(1, 0, 0, 0, 0,  1, 1,  0,    0,  1);
        vecs[12] = mk(1, 0, 0, 0, 0,  1, 1,  1,    0,  1);
        vecs[13] = mk(1, 0, 0, 0, 1,  1, 1,  1,    1,  1);
        vecs[14] = mk(1, 0, 0, 0, 1,  1, 1,  1,    2,  1);
        vecs[15] = mk(1, 0, 0, 0, 1,  1, 1,  1,    3,  1);
        vecs[16] = mk(1, 0, 0, 0, 0,  1, 1,  0,    3,  1);
        vecs[17] = mk(1, 0, 0, 0, 1,  1, 1,  0,    3,  1);
        vecs[18] = mk(0, 0, 1, 0, 0,  1, 1,  0,    0,  3);

        tick(2);
        check_all("reset", 0, 0, 0, 2'd0, 2'd0, 0);
        rst = 1'b0;

        // Unopposed extensions saturate; opposed ones stop at the budget.
        for (int i = 0; i < 19; i++) begin
            lights(vecs[i].ga, vecs[i].gb, vecs[i].ya, vecs[i].yb);
            bus.fin      = vecs[i].fin;
            bus.sensor_a = vecs[i].sa;
            bus.sensor_b = vecs[i].sb;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_grant, 0, 0,
                      vecs[i].e_cnt, vecs[i].e_srv, 0);
        end
        bus.fin = 0;

        // Pedestrian request against A withdraws the extension.
        lights(1, 0, 0, 0);
        bus.sensor_a = 1; bus.sensor_b = 0;
        tick(4);
        check_all("ped_pre", 1, 0, 0, 2'd0, 2'd1, 0);
        press_a();
        check_all("ped_latched", 0, 1, 0, 2'd0, 2'd1, 0);
        lights(0, 0, 1, 0);
        tick();
        check_all("ped_clear_phase", 0, 1, 0, 2'd0, 2'd3, 0);
        lights(0, 1, 0, 0);
        tick();
        check_all("ped_entry_b", 0, 0, 0, 2'd0, 2'd2, 0);

        // B green: A's vehicle has priority; a press under green_b is ignored.
        bus.sensor_b = 1;
        tick(4);
        check_all("b_a_priority", 0, 0, 0, 2'd0, 2'd2, 0);
        press_a();
        check_all("ped_blocked", 0, 0, 0, 2'd0, 2'd2, 0);
        bus.sensor_a = 0;
        tick(2);
        check("b_grant_lat2", {7'd0, bus.ext_grant}, 8'd0);
        tick();
        check("b_grant_lat3", {7'd0, bus.ext_grant}, 8'd1);

        // Reset mid-SERVE_B with spent budget and a pending pedestrian.
        bus.fin = 1;
        tick(2);
        bus.fin = 0;
        lights(0, 0, 0, 0);
        press_a();
        check_all("pre_rst", 1, 1, 0, 2'd2, 2'd2, 0);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 2'd0, 2'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        lights(1, 0, 0, 0);
        tick();
        check_all("post_rst_green", 0, 0, 0, 2'd0, 2'd1, 0);

        // Illegal light combination: sticky error, forced idle, no grant.
        bus.sensor_a = 1;
        tick(3);
        check("pre_err_grant", {7'd0, bus.ext_grant}, 8'd1);
        lights(1, 1, 0, 0);
        tick();
        check_all("err_set", 0, 0, 0, 2'd0, 2'd0, 1);
        lights(1, 0, 0, 0);
        tick(3);
        check_all("err_sticky", 0, 0, 0, 2'd0, 2'd0, 1);
        #2 rst = 1'b1;
        #1 check("err_rst", {7'd0, bus.err}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        lights(1, 0, 0, 1);
        tick();
        check_all("err_green_yellow", 0, 0, 0, 2'd0, 2'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
